// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HALT  = 2'd2
  } arbState_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_BURST_LEN  = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after start, wrapping.
// Purely combinational, no backpressure.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] winner,
  output logic          found
);

  // Scan from the far end so the candidate closest to start is written last.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = |req;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(start) + i) % N;
      if (req[idx]) winner = IW'(idx);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter writing N requesters into one FIFO; write data 1 cycle after accept.
// Backpressure: ReqReady drops when the tracked occupancy is full or after a FIFO error (HALT).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                              Clock,
  input  logic                              Reset,
  input  logic [NUM_REQ-1:0]                ReqValid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     ReqData,
  output logic [NUM_REQ-1:0]                ReqReady,
  input  logic                              FifoReadEn,
  input  logic                              FifoEmpty_,
  input  logic                              FifoError_,
  output logic                              WriteEn,
  output logic [DATA_WIDTH-1:0]             DataIn,
  output logic [$clog2(NUM_REQ)-1:0]        GrantId,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   Occupancy,
  output logic                              ArbError
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(BURST_LEN + 1);

  arbState_t             state, stateNext;
  logic [GW-1:0]         grantNext, startIdx, winner;
  logic [BW-1:0]         beatCnt, beatNext;
  logic [OW-1:0]         occNext;
  logic                  errNext, found, notFull, transfer, readHit, burstDone;
  logic [DATA_WIDTH-1:0] grantData;

  assign notFull   = Occupancy < OW'(FIFO_DEPTH);
  assign transfer  = |(ReqValid & ReqReady);
  assign readHit   = FifoReadEn & FifoEmpty_;
  assign grantData = ReqData[int'(GrantId)*DATA_WIDTH +: DATA_WIDTH];
  assign startIdx  = (int'(GrantId) == NUM_REQ - 1) ? '0 : GrantId + GW'(1);
  assign burstDone = transfer && (beatCnt == BW'(BURST_LEN - 1));

  rr_pick #(.N(NUM_REQ), .IW(GW)) uPick (
    .req    (ReqValid),
    .start  (startIdx),
    .winner (winner),
    .found  (found)
  );

  always_comb begin
    ReqReady = '0;
    if (state == GRANT && notFull) ReqReady[GrantId] = 1'b1;
  end

  // A read at zero occupancy is an underflow: flag it but never wrap.
  always_comb begin
    occNext = Occupancy;
    errNext = ArbError;
    if (transfer && !readHit) begin
      occNext = Occupancy + OW'(1);
    end else if (readHit && !transfer && Occupancy != '0) begin
      occNext = Occupancy - OW'(1);
    end
    if (readHit && Occupancy == '0) errNext = 1'b1;
    if (!FifoError_) errNext = 1'b1;
  end

  always_comb begin
    stateNext = state;
    grantNext = GrantId;
    beatNext  = beatCnt;
    case (state)
      IDLE: begin
        if (found && notFull) begin
          stateNext = GRANT;
          grantNext = winner;
          beatNext  = '0;
        end
      end
      GRANT: begin
        if (transfer) beatNext = beatCnt + BW'(1);
        if (burstDone || !ReqValid[GrantId] || occNext == OW'(FIFO_DEPTH)) stateNext = IDLE;
      end
      HALT:    stateNext = HALT;
      default: stateNext = IDLE;
    endcase
    if (!FifoError_) stateNext = HALT;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      GrantId   <= GW'(NUM_REQ - 1);
      beatCnt   <= '0;
      Occupancy <= '0;
      ArbError  <= 1'b0;
      WriteEn   <= 1'b0;
      DataIn    <= '0;
    end else begin
      state     <= stateNext;
      GrantId   <= grantNext;
      beatCnt   <= beatNext;
      Occupancy <= occNext;
      ArbError  <= errNext;
      WriteEn   <= transfer;
      if (transfer) DataIn <= grantData;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: cycle table for a single-requester burst plus directed corner sequences.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int FD = 16;
  localparam int BL = 4;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic [NR-1:0]     ReqValid = '0;
  logic [NR*DW-1:0]  ReqData;
  logic [NR-1:0]     ReqReady;
  logic              FifoReadEn = 1'b0;
  logic              FifoEmpty_ = 1'b1;
  logic              FifoError_ = 1'b1;
  logic              WriteEn;
  logic [DW-1:0]     DataIn;
  logic [1:0]        GrantId;
  logic [4:0]        Occupancy;
  logic              ArbError;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .BURST_LEN(BL)) dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqData(ReqData), .ReqReady(ReqReady),
    .FifoReadEn(FifoReadEn), .FifoEmpty_(FifoEmpty_), .FifoError_(FifoError_),
    .WriteEn(WriteEn), .DataIn(DataIn), .GrantId(GrantId), .Occupancy(Occupancy), .ArbError(ArbError)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  expReady;
    logic [1:0]  expGrant;
    logic [4:0]  expOcc;
    logic        expWe;
    logic [31:0] expData;
  } vec_t;

  vec_t          tbl[10];
  int            nVec = 0;
  int            nErr = 0;
  bit            started = 1'b0;
  logic [DW-1:0] sbq[$];
  int            gidLog[$];
  logic [NR-1:0] hsFlag = '0;
  int unsigned   cnt[NR];
  logic [DW-1:0] dataBase = 32'hA0;
  int            ord[5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic doReset;
    Reset      = 1'b1;
    FifoReadEn = 1'b0;
    FifoEmpty_ = 1'b1;
    FifoError_ = 1'b1;
    gidLog.delete();
    tick();
    Reset = 1'b0;
  endtask

  task automatic waitXfers(input int target, input string name);
    int n = 0;
    while (gidLog.size() < target && n < 300) begin
      tick();
      n++;
    end
    chk(name, 64'(gidLog.size() >= target), 64'd1);
  endtask

  task automatic waitReady0(input string name);
    int n = 0;
    while (ReqReady[0] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk(name, 64'(n < 50), 64'd1);
  endtask

  // Requester model: each requester advances its data word after every accepted beat.
  always begin
    @(posedge Clock);
    #2;
    for (int i = 0; i < NR; i++) begin
      if (Reset) cnt[i] = 0;
      else if (hsFlag[i]) cnt[i] = cnt[i] + 1;
      ReqData[i*DW +: DW] = dataBase + DW'(i * 256) + DW'(cnt[i]);
    end
  end

  // Scoreboard: accepted beats are queued, then must appear on the write port one cycle later.
  always @(negedge Clock) begin
    if (started) begin
      if (WriteEn === 1'b1 || sbq.size() != 0) begin
        if (WriteEn !== 1'b1) chk("write_missing", 64'(WriteEn), 64'd1);
        else if (sbq.size() == 0) chk("write_spurious", 64'(WriteEn), 64'd0);
        else chk("write_data", 64'(DataIn), 64'(sbq.pop_front()));
      end
      chk("ready_onehot", 64'($onehot0(ReqReady)), 64'd1);
      hsFlag = Reset ? '0 : (ReqValid & ReqReady);
      for (int i = 0; i < NR; i++) begin
        if (hsFlag[i]) begin
          sbq.push_back(ReqData[i*DW +: DW]);
          gidLog.push_back(i);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", nVec);
    $fatal(1);
  end

  initial begin
    int n;
    //             valid  ready  grant occ    we    data
    tbl[0] = '{4'h1, 4'h0, 2'd3, 5'd0, 1'b0, 32'h0};
    tbl[1] = '{4'h1, 4'h1, 2'd0, 5'd0, 1'b0, 32'h0};
    tbl[2] = '{4'h1, 4'h1, 2'd0, 5'd1, 1'b1, 32'hA0};
    tbl[3] = '{4'h1, 4'h1, 2'd0, 5'd2, 1'b1, 32'hA1};
    tbl[4] = '{4'h1, 4'h1, 2'd0, 5'd3, 1'b1, 32'hA2};
    tbl[5] = '{4'h1, 4'h0, 2'd0, 5'd4, 1'b1, 32'hA3};
    tbl[6] = '{4'h1, 4'h1, 2'd0, 5'd4, 1'b0, 32'h0};
    tbl[7] = '{4'h1, 4'h1, 2'd0, 5'd5, 1'b1, 32'hA4};
    tbl[8] = '{4'h0, 4'h1, 2'd0, 5'd6, 1'b1, 32'hA5};
    tbl[9] = '{4'h0, 4'h0, 2'd0, 5'd6, 1'b0, 32'h0};

    tick();
    tick();

    // Reset values and a single-requester burst, one IDLE gap, then a short burst.
    dataBase = 32'hA0;
    doReset();
    started = 1'b1;
    chk("rst_state", 64'(dut.state), 64'(IDLE));
    chk("rst_dataIn", 64'(DataIn), 64'd0);
    chk("rst_arbError", 64'(ArbError), 64'd0);
    for (int k = 0; k < 10; k++) begin
      ReqValid = tbl[k].valid;
      chk($sformatf("tbl%0d_ready", k), 64'(ReqReady), 64'(tbl[k].expReady));
      chk($sformatf("tbl%0d_grant", k), 64'(GrantId), 64'(tbl[k].expGrant));
      chk($sformatf("tbl%0d_occ", k), 64'(Occupancy), 64'(tbl[k].expOcc));
      chk($sformatf("tbl%0d_we", k), 64'(WriteEn), 64'(tbl[k].expWe));
      if (tbl[k].expWe) chk($sformatf("tbl%0d_data", k), 64'(DataIn), 64'(tbl[k].expData));
      tick();
    end

    // All requesters active: bursts of BL in round-robin order, then stall when full.
    dataBase = 32'h1000;
    ReqValid = '1;
    doReset();
    waitXfers(16, "rr_wait16");
    chk("rr_full_occ", 64'(Occupancy), 64'd16);
    chk("rr_full_ready", 64'(ReqReady), 64'd0);
    FifoReadEn = 1'b1;
    repeat (4) tick();
    FifoReadEn = 1'b0;
    waitXfers(20, "rr_wait20");
    chk("rr_end_occ", 64'(Occupancy), 64'd16);
    chk("rr_count", 64'(gidLog.size()), 64'd20);
    for (int k = 0; k < 20 && k < gidLog.size(); k++)
      chk($sformatf("rr_order%0d", k), 64'(gidLog[k]), 64'(ord[k/4]));
    ReqValid = '0;

    // Occupancy limit: exactly FD beats, reads with empty flag ignored, one read frees one slot.
    dataBase = 32'h2000;
    ReqValid = 4'b0001;
    doReset();
    waitXfers(16, "full_wait");
    for (int k = 0; k < 3; k++) begin
      chk("full_occ", 64'(Occupancy), 64'd16);
      chk("full_ready", 64'(ReqReady), 64'd0);
      tick();
    end
    chk("full_count", 64'(gidLog.size()), 64'd16);
    FifoReadEn = 1'b1;
    FifoEmpty_ = 1'b0;
    tick();
    FifoReadEn = 1'b0;
    FifoEmpty_ = 1'b1;
    chk("full_empty_read", 64'(Occupancy), 64'd16);
    FifoReadEn = 1'b1;
    tick();
    FifoReadEn = 1'b0;
    chk("full_read_occ", 64'(Occupancy), 64'd15);
    repeat (4) tick();
    chk("full_refill_count", 64'(gidLog.size()), 64'd17);
    chk("full_refill_occ", 64'(Occupancy), 64'd16);
    chk("full_refill_ready", 64'(ReqReady), 64'd0);
    ReqValid = '0;

    // Transfer and counted read in the same cycle at occupancy 8.
    dataBase = 32'h3000;
    ReqValid = 4'b0001;
    doReset();
    n = 0;
    while (!(ReqReady[0] === 1'b1 && Occupancy == 5'd8) && n < 100) begin
      tick();
      n++;
    end
    chk("simul_reach8", 64'(n < 100), 64'd1);
    FifoReadEn = 1'b1;
    tick();
    FifoReadEn = 1'b0;
    ReqValid   = '0;
    chk("simul_occ", 64'(Occupancy), 64'd8);
    chk("simul_count", 64'(gidLog.size()), 64'd9);
    tick();
    chk("simul_occ_hold", 64'(Occupancy), 64'd8);

    // FIFO error mid-burst: HALT persists, reads still tracked, reset clears.
    dataBase = 32'h4000;
    ReqValid = 4'b0001;
    doReset();
    waitReady0("halt_wait");
    tick();
    FifoError_ = 1'b0;
    tick();
    FifoError_ = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("halt_state", 64'(dut.state), 64'(HALT));
      chk("halt_err", 64'(ArbError), 64'd1);
      chk("halt_ready", 64'(ReqReady), 64'd0);
      tick();
    end
    chk("halt_occ", 64'(Occupancy), 64'd2);
    FifoReadEn = 1'b1;
    tick();
    FifoReadEn = 1'b0;
    chk("halt_read_occ", 64'(Occupancy), 64'd1);
    ReqValid = '0;
    doReset();
    chk("halt_rst_state", 64'(dut.state), 64'(IDLE));
    chk("halt_rst_occ", 64'(Occupancy), 64'd0);
    chk("halt_rst_err", 64'(ArbError), 64'd0);

    // Underflow: counted read at empty sets the sticky error without wrapping.
    FifoReadEn = 1'b1;
    tick();
    FifoReadEn = 1'b0;
    chk("uflow_err", 64'(ArbError), 64'd1);
    chk("uflow_occ", 64'(Occupancy), 64'd0);
    tick();
    chk("uflow_sticky", 64'(ArbError), 64'd1);
    doReset();
    chk("uflow_rst_err", 64'(ArbError), 64'd0);

    // Reset landing on a transfer cycle: that beat is dropped.
    dataBase = 32'h5000;
    ReqValid = 4'b0001;
    doReset();
    waitReady0("rstx_wait");
    tick();
    chk("rstx_ready_before", 64'(ReqReady), 64'd1);
    Reset = 1'b1;
    tick();
    Reset    = 1'b0;
    ReqValid = '0;
    chk("rstx_we", 64'(WriteEn), 64'd0);
    chk("rstx_occ", 64'(Occupancy), 64'd0);
    chk("rstx_ready", 64'(ReqReady), 64'd0);
    chk("rstx_grant", 64'(GrantId), 64'd3);
    tick();
    chk("rstx_we_after", 64'(WriteEn), 64'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
